// File: rtl/systolic_job_arbiter.sv
// rtl/systolic_job_arbiter.sv - round-robin arbiter and job sequencer for one shared 4x4 systolic core
//
// Purpose: NUM_REQ requesters compete for one matmul core. A round-robin arbiter picks an
// owner, then the sequencer runs the job: start pulse, IN_BEATS operand words to the core,
// wait for results (watchdog-guarded), OUT_BEATS result words back to the owner, release.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   req_start/req_data/req_valid       per-requester job request and operand stream
//   req_ready                          operand accepted (owner only)
//   rsp_data/rsp_valid/rsp_ready       result stream, data broadcast, valid to owner only
//   grant, busy                        one-hot owner (0 when idle), not-idle flag
//   job_done, job_err                  completion / watchdog-abort pulses
//   core_start, core_abort             core control pulses
//   core_in_data/valid/ready           operand stream to the core
//   core_out_data/valid/ready          result stream from the core
module systolic_job_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DW          = 64,
  parameter int IN_BEATS    = 4,
  parameter int OUT_BEATS   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_start,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_err,
  output logic                  core_start,
  output logic [DW-1:0]         core_in_data,
  output logic                  core_in_valid,
  input  logic                  core_in_ready,
  input  logic [DW-1:0]         core_out_data,
  input  logic                  core_out_valid,
  output logic                  core_out_ready,
  output logic                  core_abort
);

  localparam int GW   = $clog2(NUM_REQ);
  localparam int MAXB = (IN_BEATS > OUT_BEATS) ? IN_BEATS : OUT_BEATS;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam int WW   = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, START, FEED_IN, WAIT_OUT, DRAIN, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant, gidx, arb_idx, cand;
  logic          arb_hit;
  logic [CW-1:0] beat_cnt;
  logic [WW-1:0] wd_cnt;
  logic          in_fire, out_fire, in_last, out_last, wd_expired;

  assign in_fire    = (state == FEED_IN) && req_valid[gidx] && core_in_ready;
  assign out_fire   = (state == DRAIN) && core_out_valid && rsp_ready[gidx];
  assign in_last    = in_fire && (beat_cnt == CW'(IN_BEATS - 1));
  assign out_last   = out_fire && (beat_cnt == CW'(OUT_BEATS - 1));
  // A result showing up in the same cycle as expiry wins over the abort.
  assign wd_expired = (state == WAIT_OUT) && !core_out_valid && (wd_cnt == WW'(TIMEOUT_CYC - 1));
  assign busy       = (state != IDLE);

  // Round-robin: first requester after last_grant, wrapping around.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!arb_hit && req_start[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arb_hit) state_nxt = START;
      START:    state_nxt = FEED_IN;
      FEED_IN:  if (in_last) state_nxt = WAIT_OUT;
      WAIT_OUT: begin
        if (core_out_valid)  state_nxt = DRAIN;
        else if (wd_expired) state_nxt = RELEASE;
      end
      DRAIN:    if (out_last) state_nxt = RELEASE;
      RELEASE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      gidx       <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      wd_cnt     <= '0;
      job_done   <= 1'b0;
    end else begin
      job_done <= out_last;
      if (state == IDLE && arb_hit) begin
        gidx  <= arb_idx;
        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
      end
      if (state == RELEASE) begin
        last_grant <= gidx;
        grant      <= '0;
      end
      if (state == START || in_last || out_last) beat_cnt <= '0;
      else if (in_fire || out_fire)             beat_cnt <= beat_cnt + CW'(1);
      if (state == WAIT_OUT) wd_cnt <= wd_cnt + WW'(1);
      else                   wd_cnt <= '0;
    end
  end

  // Both streams are combinational pass-throughs to/from the current owner.
  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    rsp_data       = '0;
    core_start     = 1'b0;
    core_in_data   = '0;
    core_in_valid  = 1'b0;
    core_out_ready = 1'b0;
    core_abort     = 1'b0;
    job_err        = 1'b0;
    case (state)
      START: core_start = 1'b1;
      FEED_IN: begin
        core_in_valid   = req_valid[gidx];
        core_in_data    = req_data[int'(gidx)*DW +: DW];
        req_ready[gidx] = core_in_ready;
      end
      WAIT_OUT: begin
        core_abort = wd_expired;
        job_err    = wd_expired;
      end
      DRAIN: begin
        rsp_valid[gidx] = core_out_valid;
        rsp_data        = core_out_data;
        core_out_ready  = rsp_ready[gidx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// tb/tb_systolic_job_arbiter.sv - randomized scoreboard bench for systolic_job_arbiter
module tb_systolic_job_arbiter;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int IB = 4;
  localparam int OB = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_start, req_valid, req_ready, rsp_valid, rsp_ready, grant;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]  rsp_data, core_in_data, core_out_data;
  logic busy, job_done, job_err, core_start, core_in_valid, core_in_ready;
  logic core_out_valid, core_out_ready, core_abort;

  always #5 clk = ~clk;

  systolic_job_arbiter #(.NUM_REQ(NR), .DW(DW), .IN_BEATS(IB), .OUT_BEATS(OB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .grant(grant), .busy(busy), .job_done(job_done), .job_err(job_err), .core_start(core_start),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_abort(core_abort)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got no matching event, expected one (cycle %0d)", name, cyc);
  endtask

  // Scoreboard and shared stimulus state
  logic [NR-1:0] exp_grant_q[$];
  bit            exp_err_q[$];
  logic [DW-1:0] exp_in_q[$];
  logic [DW-1:0] exp_rsp_q[$];
  logic [DW-1:0] core_res_q[$];
  bit            core_hang_q[$];
  logic [DW-1:0] op_mem [NR][IB];
  logic [NR-1:0] phase_starts = '0;
  int            phase_go = 0;
  bit            drop_early = 1'b0;
  int            jobs_ended = 0;
  int            mon_rsp = 0;
  int            model_last = NR - 1;

  // Requesters and core model, updated 1 time unit after each rising edge.
  initial begin : agents
    int op_ptr [NR];
    int cst, in_cnt, res_cnt, delay, phase_seen;
    bit hang, inf, outf, st, ab, fin;
    logic [NR-1:0] g_s, hs;
    for (int i = 0; i < NR; i++) op_ptr[i] = IB;
    cst = 0; in_cnt = 0; res_cnt = 0; delay = 0; phase_seen = 0; hang = 1'b0;
    req_start = '0; req_valid = '0; req_data = '0; rsp_ready = '0;
    core_in_ready = 1'b0; core_out_valid = 1'b0; core_out_data = '0;
    forever begin
      @(negedge clk);
      inf  = core_in_valid && core_in_ready;
      outf = core_out_valid && core_out_ready;
      st   = core_start;
      ab   = core_abort;
      fin  = job_done || job_err;
      g_s  = grant;
      hs   = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        cst = 0;
        req_start = '0;
        for (int i = 0; i < NR; i++) op_ptr[i] = IB;
      end else begin
        for (int i = 0; i < NR; i++) if (hs[i]) op_ptr[i]++;
        if (fin || (drop_early && inf)) req_start = req_start & ~g_s;
        if (phase_go != phase_seen) begin
          phase_seen = phase_go;
          req_start = req_start | phase_starts;
          for (int i = 0; i < NR; i++) if (phase_starts[i]) op_ptr[i] = 0;
        end
        if (st) begin
          cst = 1; in_cnt = 0; res_cnt = 0;
          hang = (core_hang_q.size() > 0) ? core_hang_q.pop_front() : 1'b0;
        end else if (ab) begin
          cst = 0;
        end else if (cst == 1 && inf) begin
          in_cnt++;
          if (in_cnt == IB) begin cst = 2; delay = $urandom_range(0, 4); end
        end else if (cst == 2 && !hang) begin
          if (delay == 0) cst = 3; else delay--;
        end else if (cst == 3 && outf) begin
          if (core_res_q.size() > 0) void'(core_res_q.pop_front());
          res_cnt++;
          if (res_cnt == OB) cst = 0;
        end
      end
      core_in_ready  = (cst == 1) && ($urandom_range(0, 3) != 0);
      core_out_valid = (cst == 3) && ($urandom_range(0, 3) != 0);
      core_out_data  = (cst == 3 && core_res_q.size() > 0) ? core_res_q[0] : {$urandom, $urandom};
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (op_ptr[i] < IB) && ($urandom_range(0, 2) != 0);
        req_data[i*DW +: DW] = (op_ptr[i] < IB) ? op_mem[i][op_ptr[i]] : {$urandom, $urandom};
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer or pulse.
  initial begin : monitor
    int in_n, out_n, last_in_cyc, end_cyc, gap_exp, post;
    logic [NR-1:0] cur_g;
    bit cur_err;
    in_n = 0; out_n = 0; last_in_cyc = 0; end_cyc = 0; gap_exp = 0; post = 0;
    cur_g = '0; cur_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_n = 0; out_n = 0; gap_exp = 0; post = 0; mon_rsp = 0;
      end else begin
        if (busy && (req_valid & ~grant) != '0)
          check("ready_to_non_granted", 64'(req_ready & ~grant), 64'd0);
        if (!busy && core_out_data != '0) check("rsp_data_idle", rsp_data, 64'd0);
        if (core_abort != job_err) check("abort_with_err", 64'(core_abort), 64'(job_err));
        if (core_start) begin
          if (exp_grant_q.size() == 0) fail("unexpected_start");
          else begin
            cur_g   = exp_grant_q.pop_front();
            cur_err = exp_err_q.pop_front();
            check("grant", 64'(grant), 64'(cur_g));
          end
          if (gap_exp != 0) check("regrant_gap", 64'(cyc - end_cyc), 64'(gap_exp));
          gap_exp = 0; in_n = 0; out_n = 0; mon_rsp = 0;
        end
        if (core_in_valid && core_in_ready) begin
          if (exp_in_q.size() == 0) fail("extra_operand_beat");
          else check("core_in_data", core_in_data, exp_in_q.pop_front());
          in_n++;
          if (in_n == IB) last_in_cyc = cyc;
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          check("rsp_valid_owner", 64'(rsp_valid), 64'(cur_g));
          if (exp_rsp_q.size() == 0) fail("extra_result_beat");
          else check("rsp_data", rsp_data, exp_rsp_q.pop_front());
          out_n++;
          mon_rsp = out_n;
        end
        if (job_done || job_err) begin
          jobs_ended++;
          check("end_kind", 64'({job_err, job_done}), cur_err ? 64'd2 : 64'd1);
          check("end_grant", 64'(grant), 64'(cur_g));
          if (job_err) check("watchdog_cycles", 64'(cyc - last_in_cyc), 64'(TO));
          else         check("out_beats", 64'(out_n), 64'(OB));
          check("in_beats", 64'(in_n), 64'(IB));
          end_cyc = cyc;
          gap_exp = (exp_grant_q.size() > 0) ? (job_err ? 3 : 2) : 0;
          post    = job_err ? 2 : 1;
        end else if (post > 0) begin
          post--;
          if (post == 0) check("idle_after_job", 64'({busy, grant}), 64'd0);
        end
      end
    end
  end

  // Reference model: pending set served in round-robin order from the last owner.
  task automatic plan(input logic [NR-1:0] starts, input logic [NR-1:0] hang_mask);
    logic [NR-1:0] p;
    logic [DW-1:0] w;
    int pick;
    for (int i = 0; i < NR; i++)
      if (starts[i]) for (int b = 0; b < IB; b++) op_mem[i][b] = {$urandom, $urandom};
    p = starts;
    while (p != '0) begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && p[(model_last + k) % NR]) pick = (model_last + k) % NR;
      p[pick] = 1'b0;
      model_last = pick;
      exp_grant_q.push_back(NR'(1) << pick);
      exp_err_q.push_back(hang_mask[pick]);
      core_hang_q.push_back(hang_mask[pick]);
      for (int b = 0; b < IB; b++) exp_in_q.push_back(op_mem[pick][b]);
      if (!hang_mask[pick])
        for (int r = 0; r < OB; r++) begin
          w = {$urandom, $urandom};
          core_res_q.push_back(w);
          exp_rsp_q.push_back(w);
        end
    end
    phase_starts = starts;
    phase_go++;
  endtask

  task automatic run_phase(input logic [NR-1:0] starts, input logic [NR-1:0] hang_mask, input bit early);
    int target;
    int budget;
    target = jobs_ended + $countones(starts);
    drop_early = early;
    plan(starts, hang_mask);
    budget = 0;
    while (jobs_ended < target && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (jobs_ended < target) fail("phase_timeout");
    repeat (4) @(posedge clk);
    check("queues_drained", 64'(exp_in_q.size() + exp_rsp_q.size() + exp_grant_q.size()), 64'd0);
  endtask

  initial begin : main
    int budget;
    @(negedge clk);
    check("reset_ctrl_outputs", 64'({req_ready, rsp_valid, grant, busy, job_done, job_err,
          core_start, core_in_valid, core_out_ready, core_abort}), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);

    run_phase(4'b1111, 4'b0000, 1'b0);
    run_phase(4'b0100, 4'b0000, 1'b1);
    run_phase(4'b0001, 4'b0000, 1'b0);
    run_phase(4'b1010, 4'b0010, 1'b0);
    for (int p = 0; p < 8; p++)
      run_phase(4'($urandom_range(1, 15)),
                4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), 1'b0);

    drop_early = 1'b0;
    plan(4'b0010, 4'b0000);
    budget = 0;
    while (!(exp_grant_q.size() == 0 && mon_rsp >= 3) && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    if (budget >= 3000) fail("drain_reached");
    #2 reset = 1'b1;
    @(negedge clk);
    check("midjob_reset_ctrl", 64'({req_ready, rsp_valid, grant, busy, job_done, job_err,
          core_start, core_in_valid, core_out_ready, core_abort}), 64'd0);
    check("midjob_reset_rsp_data", rsp_data, 64'd0);
    check("midjob_reset_core_in_data", core_in_data, 64'd0);
    exp_grant_q.delete(); exp_err_q.delete(); exp_in_q.delete();
    exp_rsp_q.delete(); core_res_q.delete(); core_hang_q.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_last = NR - 1;
    repeat (2) @(posedge clk);
    run_phase(4'b1111, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
